// File: rtl/timer_irq_servicer.sv
// Interval-timer programmer and irq servicer that paces the video pipeline.
// Optional overrun counter enabled by defining TIMER_SERVICER_OVERRUN_EN.
module timer_irq_servicer #(
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cfg_period,
    input  logic        cfg_start,
    input  logic        cfg_stop,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic        tmr_irq,
    output logic        frame_tick,
    input  logic        frame_ready,
    output logic [15:0] tick_count,
    output logic        busy,
    output logic [7:0]  overrun_count
);

    typedef enum logic [2:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_STS, SETTLE, STOP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(TICK_DIV - 1);

    state_t      state;
    logic [31:0] period;
    logic [31:0] period_in;
    logic [7:0]  divider;
    logic        stop_pending;
    logic        tick_event;

    // Periods below 8 cycles would bury the core in interrupts.
    assign period_in  = (cfg_period < 32'd8) ? 32'd8 : cfg_period;
    assign tick_event = (state == CLR_STS) && (divider == DIV_LAST);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            period         <= '0;
            divider        <= '0;
            tick_count     <= '0;
            stop_pending   <= 1'b0;
            frame_tick     <= 1'b0;
            tmr_address    <= '0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_writedata  <= '0;
        end else begin
            tmr_address    <= '0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_writedata  <= '0;
            if (state != IDLE && cfg_stop)
                stop_pending <= 1'b1;
            if (frame_tick && frame_ready)
                frame_tick <= 1'b0;
            // A pending tick simply stays high; the new event is dropped.
            if (tick_event)
                frame_tick <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (cfg_start) begin
                        period         <= period_in;
                        tick_count     <= '0;
                        divider        <= '0;
                        state          <= WR_PL;
                        tmr_address    <= 3'd2;
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                        tmr_writedata  <= period_in[15:0];
                    end
                end
                WR_PL: begin
                    state          <= WR_PH;
                    tmr_address    <= 3'd3;
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_writedata  <= period[31:16];
                end
                WR_PH: begin
                    state          <= WR_CTRL;
                    tmr_address    <= 3'd1;
                    tmr_chipselect <= 1'b1;
                    tmr_write_n    <= 1'b0;
                    tmr_writedata  <= 16'h0007;
                end
                WR_CTRL: state <= RUN;
                RUN: begin
                    if (tmr_irq) begin
                        state          <= CLR_STS;
                        tmr_address    <= 3'd0;
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                    end else if (stop_pending || cfg_stop) begin
                        state          <= STOP;
                        tmr_address    <= 3'd1;
                        tmr_chipselect <= 1'b1;
                        tmr_write_n    <= 1'b0;
                        tmr_writedata  <= 16'h0008;
                    end
                end
                CLR_STS: begin
                    tick_count <= tick_count + 16'd1;
                    divider    <= tick_event ? 8'd0 : divider + 8'd1;
                    state      <= SETTLE;
                end
                SETTLE: state <= RUN;
                STOP: begin
                    stop_pending <= 1'b0;
                    frame_tick   <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef TIMER_SERVICER_OVERRUN_EN
    logic overrun;
    assign overrun = tick_event && frame_tick && !frame_ready;

    always_ff @(posedge clk) begin
        if (reset)
            overrun_count <= '0;
        else if (state == IDLE && cfg_start)
            overrun_count <= '0;
        else if (overrun && overrun_count != 8'hFF)
            overrun_count <= overrun_count + 8'd1;
    end
`else
    assign overrun_count = '0;
`endif

endmodule

// File: tb/tb_timer_irq_servicer.sv
// Directed bench: programming table plus irq, overrun, stop and reset sequences.
module tb_timer_irq_servicer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cfg_period;
    logic        cfg_start;
    logic        cfg_stop;
    logic        tmr_irq;
    logic        frame_ready;

    logic [2:0]  a_addr, b_addr;
    logic        a_cs, b_cs, a_wn, b_wn;
    logic [15:0] a_wd, b_wd;
    logic        a_ft, b_ft;
    logic [15:0] a_tc, b_tc;
    logic        a_busy, b_busy;
    logic [7:0]  a_ovr, b_ovr;

    int n_vec = 0;
    int n_bad = 0;
    int hs_a = 0;
    int hs_b = 0;

    always #5 clk = ~clk;

    timer_irq_servicer #(.TICK_DIV(2)) u_dut (
        .clk(clk), .reset(reset), .cfg_period(cfg_period),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .tmr_address(a_addr), .tmr_chipselect(a_cs),
        .tmr_write_n(a_wn), .tmr_writedata(a_wd),
        .tmr_irq(tmr_irq), .frame_tick(a_ft), .frame_ready(frame_ready),
        .tick_count(a_tc), .busy(a_busy), .overrun_count(a_ovr)
    );

    timer_irq_servicer #(.TICK_DIV(1)) u_div1 (
        .clk(clk), .reset(reset), .cfg_period(cfg_period),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .tmr_address(b_addr), .tmr_chipselect(b_cs),
        .tmr_write_n(b_wn), .tmr_writedata(b_wd),
        .tmr_irq(tmr_irq), .frame_tick(b_ft), .frame_ready(frame_ready),
        .tick_count(b_tc), .busy(b_busy), .overrun_count(b_ovr)
    );

    always @(posedge clk) begin
        if (!reset && a_ft && frame_ready) hs_a <= hs_a + 1;
        if (!reset && b_ft && frame_ready) hs_b <= hs_b + 1;
    end

    typedef struct {
        logic [31:0] period;
        logic [15:0] lo;
        logic [15:0] hi;
    } prog_vec_t;

    prog_vec_t pv[7];

`ifdef TIMER_SERVICER_OVERRUN_EN
    localparam int EXP_OVR = 2;
`else
    localparam int EXP_OVR = 0;
`endif

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Checks the bus of the TICK_DIV=2 instance: {cs, write_n, addr, data}
    task automatic chk_bus(input string name, input logic cs,
                           input logic [2:0] addr, input logic [15:0] data);
        chk(name, {a_cs, a_wn, a_addr, a_wd}, {cs, ~cs, addr, data});
    endtask

    task automatic do_irq();
        tmr_irq = 1'b1;
        tick();
        chk_bus("irq_clr_write", 1'b1, 3'd0, 16'h0000);
        tmr_irq = 1'b0;
        tick();
        chk_bus("settle_no_write", 1'b0, 3'd0, 16'h0000);
        tick();
    endtask

    task automatic start_to_run(input logic [31:0] p);
        cfg_period = p;
        cfg_start  = 1'b1;
        tick();
        cfg_start  = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        pv[0] = '{32'h0001E847, 16'hE847, 16'h0001};
        pv[1] = '{32'h00000003, 16'h0008, 16'h0000};
        pv[2] = '{32'h00000000, 16'h0008, 16'h0000};
        pv[3] = '{32'h00000007, 16'h0008, 16'h0000};
        pv[4] = '{32'h00000008, 16'h0008, 16'h0000};
        pv[5] = '{32'h00000009, 16'h0009, 16'h0000};
        pv[6] = '{32'hFFFFFFFF, 16'hFFFF, 16'hFFFF};

        reset = 1'b1; cfg_period = '0; cfg_start = 1'b0;
        cfg_stop = 1'b0; tmr_irq = 1'b0; frame_ready = 1'b1;
        tick();
        tick();
        chk_bus("reset_bus", 1'b0, 3'd0, 16'h0000);
        chk("reset_busy", a_busy, 0);
        chk("reset_ft", a_ft, 0);
        chk("reset_tc", a_tc, 0);
        chk("reset_ovr", b_ovr, 0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            cfg_period = pv[i].period;
            cfg_start  = 1'b1;
            tick();
            cfg_start  = 1'b0;
            chk_bus("prog_pl", 1'b1, 3'd2, pv[i].lo);
            chk("prog_busy", a_busy, 1);
            tick();
            chk_bus("prog_ph", 1'b1, 3'd3, pv[i].hi);
            tick();
            chk_bus("prog_ctrl", 1'b1, 3'd1, 16'h0007);
            tick();
            chk_bus("prog_run_idle_bus", 1'b0, 3'd0, 16'h0000);
            cfg_stop = 1'b1;
            tick();
            cfg_stop = 1'b0;
            chk_bus("prog_stop", 1'b1, 3'd1, 16'h0008);
            tick();
            chk("prog_idle_busy", a_busy, 0);
            chk_bus("prog_idle_bus", 1'b0, 3'd0, 16'h0000);
        end

        // Four serviced irqs with the pipeline always ready.
        frame_ready = 1'b1;
        start_to_run(32'd100);
        do_irq();
        chk("div2_ft_after_1", a_ft, 0);
        chk("div1_tc_1", b_tc, 1);
        do_irq();
        do_irq();
        do_irq();
        chk("div2_tc_4", a_tc, 4);
        chk("div2_handshakes", hs_a, 2);
        chk("div1_handshakes", hs_b, 4);

        // Start while running must be ignored.
        cfg_period = 32'h1234;
        cfg_start  = 1'b1;
        tick();
        cfg_start  = 1'b0;
        chk_bus("start_ignored", 1'b0, 3'd0, 16'h0000);
        chk("start_ignored_tc", a_tc, 4);

        // Pipeline stalled: three irqs.
        frame_ready = 1'b0;
        do_irq();
        chk("div1_ft_held_1", b_ft, 1);
        do_irq();
        do_irq();
        chk("div1_ft_held_3", b_ft, 1);
        chk("div1_overrun", b_ovr, EXP_OVR);
        chk("div2_ft_pending", a_ft, 1);
        chk("div2_overrun", a_ovr, 0);
        chk("stall_hs_b", hs_b, 4);
        frame_ready = 1'b1;
        tick();
        chk("release_ft_low", b_ft, 0);
        chk("release_hs_b", hs_b, 5);
        chk("release_hs_a", hs_a, 3);

        // Stop coincident with irq: service first, then stop.
        frame_ready = 1'b0;
        tmr_irq  = 1'b1;
        cfg_stop = 1'b1;
        tick();
        tmr_irq  = 1'b0;
        cfg_stop = 1'b0;
        chk_bus("stop_irq_clr", 1'b1, 3'd0, 16'h0000);
        tick();
        chk_bus("stop_settle", 1'b0, 3'd0, 16'h0000);
        tick();
        chk_bus("stop_run", 1'b0, 3'd0, 16'h0000);
        chk("stop_run_ft", b_ft, 1);
        tick();
        chk_bus("stop_write", 1'b1, 3'd1, 16'h0008);
        tick();
        chk("stop_idle_busy", a_busy, 0);
        chk("stop_idle_ft", b_ft, 0);
        chk("stop_tc", a_tc, 8);
        chk("stop_ovr_kept", b_ovr, EXP_OVR);
        frame_ready = 1'b1;

        cfg_stop = 1'b1;
        tick();
        tick();
        cfg_stop = 1'b0;
        chk_bus("idle_stop_noop", 1'b0, 3'd0, 16'h0000);
        chk("idle_stop_busy", a_busy, 0);

        // Restart clears counters; then reset mid-programming.
        cfg_period = 32'h00020003;
        cfg_start  = 1'b1;
        tick();
        cfg_start  = 1'b0;
        chk("restart_ovr_clr", b_ovr, 0);
        chk("restart_tc_clr", b_tc, 0);
        tick();
        chk_bus("rst_in_ph", 1'b1, 3'd3, 16'h0002);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_bus("rst_abort_bus", 1'b0, 3'd0, 16'h0000);
        chk("rst_abort_busy", a_busy, 0);
        chk("rst_abort_tc", a_tc, 0);
        tick();
        chk_bus("rst_no_more_writes", 1'b0, 3'd0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
